// File: rtl/morse_pkg.sv
// Shared symbol codes, field widths and FSM states for the morse keyer path.
// Pure definitions: no latency, no flow control.
package morse_pkg;
    localparam int TAG_W     = 2;
    localparam int PAYLOAD_W = 18;
    localparam int SYM_W     = 2;
    localparam int SLOTS     = 9;
    localparam int NSYM_W    = $clog2(SLOTS + 1);
    localparam int WDATA_W   = TAG_W + PAYLOAD_W;

    localparam logic [SYM_W-1:0] SYM_EMPTY = 2'b00;
    localparam logic [SYM_W-1:0] SYM_DOT   = 2'b01;
    localparam logic [SYM_W-1:0] SYM_DASH  = 2'b10;
    localparam logic [SYM_W-1:0] SYM_SPACE = 2'b11;

    localparam logic [PAYLOAD_W-1:0] WORD_SPACE_PAYLOAD = {{(PAYLOAD_W-SYM_W){1'b0}}, SYM_SPACE};

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        WORDWAIT
    } state_e;
endpackage

// File: rtl/morse_keyer_key_debounce.sv
// Two-flop synchronizer plus stability counter for the raw straight key.
// Latency: 2 sync cycles + DEBOUNCE cycles per level change; no backpressure.
module key_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_key_db
);
    localparam int DB_W = $clog2(DEBOUNCE + 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            key_db_q;
    logic            key_db_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;

    // Any cycle agreeing with the current level restarts the stability count.
    always_comb begin
        db_cnt_d = '0;
        key_db_d = key_db_q;
        if (sync2_q != key_db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
                key_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            key_db_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= i_key;
            sync2_q  <= sync1_q;
            key_db_q <= key_db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign o_key_db = key_db_q;
endmodule

// File: rtl/morse_keyer.sv
// Times debounced key presses into dots/dashes, packs letters, publishes them (and word spaces) on a held tagged output.
// Latency: publish is registered, LETTER_GAP/WORD_GAP cycles after FSM sees release; no backpressure, i_buff_warn only flags loss.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int DEBOUNCE   = 4,
    parameter int DOT_MAX    = 1000,
    parameter int LETTER_GAP = 3000,
    parameter int WORD_GAP   = 7000,
    parameter int CNT_W      = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_key,
    input  logic               i_buff_warn,
    output logic [WDATA_W-1:0] o_w_data,
    output logic               o_overflow,
    output logic               o_lost
);
    logic                 key_db;
    state_e               state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [PAYLOAD_W-1:0] code_q,     code_d;
    logic [NSYM_W-1:0]    nsym_q,     nsym_d;
    logic [TAG_W-1:0]     tag_q,      tag_d;
    logic [WDATA_W-1:0]   w_data_q,   w_data_d;
    logic                 overflow_q, overflow_d;
    logic                 lost_q,     lost_d;
    logic                 warn_q;
    logic                 publish;
    logic [PAYLOAD_W-1:0] payload;
    logic [SYM_W-1:0]     sym;
    logic [TAG_W-1:0]     tag_inc;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_key_debounce (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_key    (i_key),
        .o_key_db (key_db)
    );

    assign tag_inc = tag_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        nsym_d     = nsym_q;
        overflow_d = overflow_q;
        publish    = 1'b0;
        payload    = code_q;
        sym        = SYM_EMPTY;

        case (state_q)
            IDLE: begin
                if (key_db) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (!key_db) begin
                    sym = (cnt_q < CNT_W'(DOT_MAX)) ? SYM_DOT : SYM_DASH;
                    if (nsym_q < NSYM_W'(SLOTS)) begin
                        code_d = {code_q[PAYLOAD_W-SYM_W-1:0], sym};
                        nsym_d = nsym_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                // A new press on the threshold cycle wins; the letter keeps growing.
                if (key_db) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LETTER_GAP - 1)) begin
                    publish = 1'b1;
                    payload = code_q;
                    code_d  = '0;
                    nsym_d  = '0;
                    state_d = WORDWAIT;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WORDWAIT: begin
                if (key_db) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(WORD_GAP - 1)) begin
                    publish = 1'b1;
                    payload = WORD_SPACE_PAYLOAD;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        tag_d    = tag_q;
        w_data_d = w_data_q;
        lost_d   = lost_q;
        if (publish) begin
            tag_d    = tag_inc;
            w_data_d = {tag_inc, payload};
            if (warn_q) begin
                lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            code_q     <= '0;
            nsym_q     <= '0;
            tag_q      <= '0;
            w_data_q   <= '0;
            overflow_q <= 1'b0;
            lost_q     <= 1'b0;
            warn_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            nsym_q     <= nsym_d;
            tag_q      <= tag_d;
            w_data_q   <= w_data_d;
            overflow_q <= overflow_d;
            lost_q     <= lost_d;
            warn_q     <= i_buff_warn;
        end
    end

    assign o_w_data   = w_data_q;
    assign o_overflow = overflow_q;
    assign o_lost     = lost_q;
endmodule
